// File: rtl/mpmc11_pkg.sv
// Shared types and default constants for the MPMC11 application write-data path.
package mpmc11_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } mpmc11_wdf_state_t;

   localparam int MPMC11_WDF_BEATS = 4;
   localparam int MPMC11_WDF_TMO   = 255;
   localparam int MPMC11_WDF_LEN_W = 4;

endpackage

// File: rtl/mpmc11_app_wdf_burst_gen.sv
// Streams one latched write burst into the memory controller's write-data FIFO.
// Optional stall abort: define MPMC11_WDF_TIMEOUT_EN to enable the wdf_rdy-low timeout.
module mpmc11_app_wdf_burst_gen
   import mpmc11_pkg::*;
#(
   parameter int BEATS = MPMC11_WDF_BEATS,
   parameter int DW    = 128,
   parameter int TMO   = MPMC11_WDF_TMO
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [MPMC11_WDF_LEN_W-1:0] len,
   input  logic [BEATS*DW-1:0]         line_i,
   input  logic [BEATS*DW/8-1:0]       mask_i,
   input  logic                        wdf_rdy,
   output logic                        wdf_wren,
   output logic                        wdf_end,
   output logic [DW-1:0]               wdf_data,
   output logic [DW/8-1:0]             wdf_mask,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout
);

   localparam int MW = DW / 8;
   localparam logic [MPMC11_WDF_LEN_W-1:0] LEN_MAX = MPMC11_WDF_LEN_W'(BEATS - 1);

   if (BEATS < 1 || BEATS > 16 || (DW % 8) != 0 || TMO < 1) begin : g_param_check
      $error("mpmc11_app_wdf_burst_gen: illegal parameter set");
   end

   mpmc11_wdf_state_t             state_q, state_d;
   logic [MPMC11_WDF_LEN_W-1:0]   beat_cnt_q;
   logic [MPMC11_WDF_LEN_W-1:0]   len_q;
   logic [BEATS*DW-1:0]           line_q;
   logic [BEATS*MW-1:0]           mask_q;
   logic                          accept;
   logic                          tmo_hit;

   assign accept = wdf_wren & wdf_rdy;

`ifdef MPMC11_WDF_TIMEOUT_EN
   localparam int SW = (TMO > 1) ? $clog2(TMO) : 1;

   logic [SW-1:0] stall_q;
   logic          timeout_q;

   // The TMO-th consecutive stalled XFER cycle aborts the burst.
   assign tmo_hit = (state_q == XFER) && !wdf_rdy && (stall_q == SW'(TMO - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit;
         if (state_q != XFER || wdf_rdy) stall_q <= '0;
         else                            stall_q <= stall_q + SW'(1);
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: state_d gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = XFER;
         XFER: begin
            if (accept && wdf_end) state_d = DONE;
            else if (tmo_hit)      state_d = IDLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wdf_wren = (state_q == XFER);
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      wdf_end  = wdf_wren && (beat_cnt_q == len_q);
      wdf_data = '0;
      wdf_mask = '0;
      // Outside XFER the counter may point past the last beat, so the mux is gated.
      if (wdf_wren) begin
         wdf_data = line_q[int'(beat_cnt_q)*DW +: DW];
         wdf_mask = mask_q[int'(beat_cnt_q)*MW +: MW];
      end
   end

   // NOTE: the wide burst buffer is reset too, so wdf_data/wdf_mask read back as zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         len_q      <= '0;
         line_q     <= '0;
         mask_q     <= '0;
      end else if (state_q == IDLE && start) begin
         beat_cnt_q <= '0;
         len_q      <= (len > LEN_MAX) ? LEN_MAX : len;
         line_q     <= line_i;
         mask_q     <= mask_i;
      end else if (accept) begin
         beat_cnt_q <= beat_cnt_q + MPMC11_WDF_LEN_W'(1);
      end
   end

endmodule

// File: tb/tb_mpmc11_app_wdf_burst_gen.sv
// Randomised burst bench with a transaction-level beat-queue model; covers clamp, stalls, reset abort
// and, when MPMC11_WDF_TIMEOUT_EN is defined, the stall timeout.
module tb_mpmc11_app_wdf_burst_gen;

   localparam int BEATS = 4;
   localparam int DW    = 32;
   localparam int MW    = DW / 8;
   localparam int TMO   = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [3:0]            len;
   logic [BEATS*DW-1:0]   line_i;
   logic [BEATS*MW-1:0]   mask_i;
   logic                  wdf_rdy;
   logic                  wdf_wren;
   logic                  wdf_end;
   logic [DW-1:0]         wdf_data;
   logic [MW-1:0]         wdf_mask;
   logic                  busy;
   logic                  done;
   logic                  timeout;

   int n_checks = 0;
   int n_bad    = 0;

   mpmc11_app_wdf_burst_gen #(.BEATS(BEATS), .DW(DW), .TMO(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .line_i   (line_i),
      .mask_i   (mask_i),
      .wdf_rdy  (wdf_rdy),
      .wdf_wren (wdf_wren),
      .wdf_end  (wdf_end),
      .wdf_data (wdf_data),
      .wdf_mask (wdf_mask),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs();
      start  = 1'($urandom_range(1));
      len    = 4'($urandom_range(15));
      line_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      mask_i = 16'($urandom());
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_wren"}, wdf_wren, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_data"}, wdf_data, '0);
   endtask

   // Entered in an observed IDLE cycle; leaves the DUT in the IDLE cycle that follows done.
   task automatic run_burst(input logic [3:0] l, input int stall_pct,
                            input int stall_beat, input int stall_len);
      logic [DW-1:0] exp_data [BEATS];
      logic [MW-1:0] exp_mask [BEATS];
      int n, sent, cyc, stalls, held, run, at_beat, guard;
      logic rdy;
      n = (int'(l) > BEATS - 1) ? BEATS : int'(l) + 1;
      start  = 1'b1;
      len    = l;
      line_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      mask_i = 16'($urandom());
      for (int b = 0; b < BEATS; b++) begin
         exp_data[b] = line_i[b*DW +: DW];
         exp_mask[b] = mask_i[b*MW +: MW];
      end
      sent = 0; cyc = 1; stalls = 0; held = 0; run = 0; at_beat = 0; guard = 0;
      tick();
      while (sent < n && guard < 200) begin
         cyc++;
         guard++;
         check("wren", wdf_wren, 1'b1);
         check("busy", busy, 1'b1);
         check("done_early", done, 1'b0);
         check("timeout_xfer", timeout, 1'b0);
         check("data", wdf_data, exp_data[sent]);
         check("mask", wdf_mask, exp_mask[sent]);
         check("end", wdf_end, sent == n - 1);
         if (sent == stall_beat) at_beat++;
         if (sent == stall_beat && held < stall_len) begin
            rdy = 1'b0;
            held++;
         end else if (stall_pct > 0 && run < 6 && $urandom_range(99) < stall_pct) begin
            rdy = 1'b0;
         end else begin
            rdy = 1'b1;
         end
         run = rdy ? 0 : run + 1;
         if (!rdy) stalls++;
         wdf_rdy = rdy;
         scramble_inputs();
         tick();
         if (rdy) sent++;
      end
      if (guard >= 200) check("burst_budget", guard, 0);
      cyc++;
      check("done_pulse", done, 1'b1);
      check("done_wren", wdf_wren, 1'b0);
      check("done_busy", busy, 1'b1);
      check("latency", cyc, n + 2 + stalls);
      if (stall_len > 0) check("held_cycles", at_beat, stall_len + 1);
      start   = 1'b0;
      wdf_rdy = 1'($urandom_range(1));
      tick();
      check_idle("post");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; line_i = '0; mask_i = '0; wdf_rdy = 1'b0;
      tick();
      tick();
      check("rst_wren", wdf_wren, 1'b0);
      check("rst_end", wdf_end, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_data", wdf_data, '0);
      check("rst_mask", wdf_mask, '0);
      rst = 1'b0;
      tick();

      run_burst(4'd3, 0, -1, 0);   // full burst: latency len+3 = 6
      run_burst(4'd1, 0, 1, 3);    // beat 1 held for four wren cycles
      run_burst(4'd0, 0, -1, 0);   // single beat with wdf_end
      run_burst(4'd7, 0, -1, 0);   // clamps to four beats
`ifndef MPMC11_WDF_TIMEOUT_EN
      run_burst(4'd2, 0, 0, 20);   // long stall must not abort
`endif
      for (int i = 0; i < 40; i++) run_burst(4'($urandom_range(15)), 35, -1, 0);

      // Reset after beat 1 of a four-beat burst.
      start = 1'b1; len = 4'd3; wdf_rdy = 1'b1;
      line_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      mask_i = 16'($urandom());
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_wren", wdf_wren, 1'b0);
      check("abort_end", wdf_end, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_timeout", timeout, 1'b0);
      check("abort_data", wdf_data, '0);
      check("abort_mask", wdf_mask, '0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_quiet", {done, timeout, wdf_wren}, 3'b000);
      end

`ifdef MPMC11_WDF_TIMEOUT_EN
      // Stall from the first beat until the limit expires.
      start = 1'b1; len = 4'd3; wdf_rdy = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         check("tmo_wren", wdf_wren, 1'b1);
         check("tmo_early", timeout, 1'b0);
         tick();
      end
      check("tmo_pulse", timeout, 1'b1);
      check("tmo_busy", busy, 1'b0);
      check("tmo_wren_off", wdf_wren, 1'b0);
      check("tmo_done", done, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("tmo_after", {timeout, done, busy}, 3'b000);
      end
      wdf_rdy = 1'b1;
      run_burst(4'd2, 0, -1, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
